// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - shared types and constants for the key conditioner
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int   SYNC_STAGES      = 2;
    localparam logic KEY_ACTIVE_LEVEL = 1'b0;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key channel: sync, debounce FSM, optional hold (KEY_CONDITIONER_LONG_PRESS_EN)
module key_debounce
    import key_cond_pkg::*;
#(
    parameter int DB_CYCLES   = 500000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int               CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_bad_params
        $error("key_debounce: DB_CYCLES and HOLD_CYCLES must both be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   raw_p;
    key_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   press_d, release_d, level_d;

    // Two-stage synchroniser; resets to the released level so a held key
    // is seen as a fresh press once reset lifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{~KEY_ACTIVE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key};
        end
    end

    assign raw_p = (sync_q[SYNC_STAGES-1] == KEY_ACTIVE_LEVEL);

    // Debounce state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            level         <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    // Next-state logic; the counter stops at CNT_MAX because that value
    // always leaves the wait state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (raw_p) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!raw_p) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!raw_p) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (raw_p) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

`ifdef KEY_CONDITIONER_LONG_PRESS_EN
    localparam int                HOLD_W   = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;

    // Long-press timer: restarts on each press, survives release bounces,
    // fires once and re-arms only after the key returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            hold_done  <= 1'b0;
            hold_pulse <= 1'b0;
        end else begin
            hold_pulse <= 1'b0;
            if (state_q == IDLE) begin
                hold_done <= 1'b0;
            end
            if (press_d) begin
                hold_cnt <= '0;
            end else if (level && !hold_done) begin
                if (hold_cnt == HOLD_MAX) begin
                    hold_pulse <= 1'b1;
                    hold_done  <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end
        end
    end
`else
    assign hold_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - N-key pushbutton conditioner; long press via KEY_CONDITIONER_LONG_PRESS_EN
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int DB_CYCLES   = 500000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_hold
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES   (DB_CYCLES),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_key (
            .clk           (CLOCK_50),
            .reset         (reset),
            .key           (KEY[i]),
            .level         (key_level[i]),
            .press_pulse   (key_press[i]),
            .release_pulse (key_release[i]),
            .hold_pulse    (key_hold[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner
module tb_key_conditioner;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int HD = 40;
    localparam int LAT = DB + 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] key = '1;
    logic [N-1:0] key_level, key_press, key_release, key_hold;

    key_conditioner #(.N_KEYS(N), .DB_CYCLES(DB), .HOLD_CYCLES(HD)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .KEY         (key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_hold    (key_hold)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int key; int kind; } ev_t;  // kind: 0 press, 1 release, 2 hold
    ev_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int holds_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_ev(input int at, input int k, input int kind);
        ev_t e;
        e.cyc = at; e.key = k; e.kind = kind;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    ev_t m_ev;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            m_ev = exp_q.pop_front();
            n_checks++;
            $display("FAIL missed_event: key %0d kind %0d expected at cycle %0d, none by cycle %0d",
                     m_ev.key, m_ev.kind, m_ev.cyc, cyc);
        end
        for (int k = 0; k < N; k++) begin
            for (int kind = 0; kind < 3; kind++) begin
                logic b;
                b = (kind == 0) ? key_press[k] : (kind == 1) ? key_release[k] : key_hold[k];
                if (b) begin
                    if (kind == 2) holds_seen++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_event: key %0d kind %0d at cycle %0d, none expected",
                                 k, kind, cyc);
                    end else begin
                        m_ev = exp_q.pop_front();
                        if (m_ev.cyc == cyc && m_ev.key == k && m_ev.kind == kind) n_pass++;
                        else $display("FAIL event: got key %0d kind %0d cycle %0d expected key %0d kind %0d cycle %0d",
                                      k, kind, cyc, m_ev.key, m_ev.kind, m_ev.cyc);
                    end
                    if (kind == 0) check("press_level_release", {30'd0, key_level[k], key_release[k]}, 32'h2);
                    if (kind == 1) check("release_level_press", {30'd0, key_level[k], key_press[k]}, 32'h0);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int bad;
        int exp_holds;

        // Reset state
        wait_cycles(3);
        check("reset_outputs", {16'd0, key_level, key_press, key_release, key_hold}, 32'h0);
        reset = 1'b0;
        wait_cycles(5);

        // Press KEY[0] and hold
        c = cyc; key[0] = 1'b0; expect_ev(c + LAT, 0, 0);
        wait_cycles(15);
        check("level_after_press", {28'd0, key_level}, 32'h1);

        // Release KEY[0] with a 3-cycle bounce
        key[0] = 1'b1; wait_cycles(3);
        key[0] = 1'b0; wait_cycles(3);
        c = cyc; key[0] = 1'b1; expect_ev(c + LAT, 0, 1);
        wait_cycles(15);

        // KEY[1] bouncing 5 low / 5 high four times: rejected
        bad = 0;
        for (int r = 0; r < 4; r++) begin
            key[1] = 1'b0;
            for (int i = 0; i < 5; i++) begin @(negedge clk); if (key_level[1]) bad++; end
            key[1] = 1'b1;
            for (int i = 0; i < 5; i++) begin @(negedge clk); if (key_level[1]) bad++; end
        end
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (key_level[1]) bad++; end
        check("bounce_level1_cycles", bad, 0);

        // KEY[2] held through reset
        reset = 1'b1; key[2] = 1'b0;
        wait_cycles(4);
        c = cyc; reset = 1'b0; expect_ev(c + LAT, 2, 0);
        wait_cycles(14);
        check("level_key2_after_reset", {28'd0, key_level}, 32'h4);

        // Reset asserted mid PRESS_WAIT on KEY[3]
        key[3] = 1'b0;
        wait_cycles(5);
        reset = 1'b1;
        wait_cycles(1);
        check("outputs_after_midreset", {16'd0, key_level, key_press, key_release, key_hold}, 32'h0);
        key = '1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(15);

        // Coincident presses on KEY[0] and KEY[3]
        c = cyc; key[0] = 1'b0; key[3] = 1'b0;
        expect_ev(c + LAT, 0, 0); expect_ev(c + LAT, 3, 0);
        wait_cycles(15);
        check("level_coincident", {28'd0, key_level}, 32'h9);
        c = cyc; key[0] = 1'b1; key[3] = 1'b1;
        expect_ev(c + LAT, 0, 1); expect_ev(c + LAT, 3, 1);
        wait_cycles(15);

        // Long hold on KEY[0]
        holds_seen = 0;
        c = cyc; key[0] = 1'b0; expect_ev(c + LAT, 0, 0);
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
        expect_ev(c + LAT + HD, 0, 2);
        exp_holds = 1;
`else
        exp_holds = 0;
`endif
        wait_cycles(60);
        c = cyc; key[0] = 1'b1; expect_ev(c + LAT, 0, 1);
        wait_cycles(15);
        check("hold_pulse_count", holds_seen, exp_holds);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
